// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and defaults for the instruction-memory loader.
//   state_t            : loader FSM state encoding
//   ADDR_W_DEFAULT     : default instruction-memory word address width
//   MAX_WORDS_DEFAULT  : default largest accepted program length in words
// CHK is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int ADDR_W_DEFAULT    = 10;
    localparam int MAX_WORDS_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler -- packs four serial bytes into one big-endian 32-bit word.
//   clk, reset      : clock, async active-low reset
//   clear           : drop any partial word (new load)
//   shift_en        : a data byte is accepted this cycle
//   byte_in         : the data byte
//   word            : assembled word (first byte in bits 31:24)
//   word_complete   : this cycle's accepted byte is the 4th of a word
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] byte_cnt;

    assign word_complete = shift_en && (byte_cnt == 2'd3);

    // Counter wraps naturally after the 4th byte, so no explicit restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- serial program loader for the pipeline processor's
// instruction memory. Receives a 16-bit big-endian word count N, then N
// big-endian 32-bit words, writing each to consecutive addresses from 0.
// The processor is held in reset until a load completes.
//   clk, reset     : clock, async active-low reset
//   start          : one-cycle load request (honoured in IDLE/DONE/ERR only)
//   byte_in/valid  : serial byte source, byte_ready is the handshake back
//   imem_we/addr/wdata : instruction-memory write port
//   cpu_reset      : active-high processor reset, low only in DONE
//   load_done      : program loaded, processor released
//   load_error     : bad header (or bad checksum) aborted the load
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte equal
// to the XOR of all data bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LAST_NEXT = CHK;
`else
    localparam state_t LAST_NEXT = DONE;
`endif

    state_t      state, state_n;
    logic [7:0]  hdr_hi_q;
    logic [15:0] rem_q;       // words still to be written
    logic [15:0] hdr_n;
    logic        hdr_bad;
    logic        accept;
    logic        start_load;
    logic        data_shift;
    logic [31:0] word;
    logic        word_complete;

    assign accept     = byte_valid && byte_ready;
    assign hdr_n      = {hdr_hi_q, byte_in};
    assign hdr_bad    = (hdr_n == 16'd0) || (32'(hdr_n) > 32'(MAX_WORDS));
    assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign data_shift = accept && (state == DATA);
    assign imem_wdata = word;

    word_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_load),
        .shift_en      (data_shift),
        .byte_in       (byte_in),
        .word          (word),
        .word_complete (word_complete)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          xor_q <= '0;
        else if (start_load) xor_q <= '0;
        else if (data_shift) xor_q <= xor_q ^ byte_in;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (accept) state_n = HDR_LO;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (accept) state_n = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                if (word_complete) state_n = WRITE;
            end
            WRITE: begin
                imem_we = 1'b1;
                state_n = (rem_q == 16'd1) ? LAST_NEXT : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (accept) state_n = (byte_in == xor_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (start) state_n = HDR_HI;
            end
            ERR: begin
                load_error = 1'b1;
                if (start) state_n = HDR_HI;
            end
            default: state_n = IDLE;
        endcase
    end

    // Address saturates at the top so a full-size program never wraps to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_hi_q  <= '0;
            rem_q     <= '0;
            imem_addr <= '0;
        end else begin
            if (start_load)
                imem_addr <= '0;
            else if ((state == WRITE) && (imem_addr != ADDR_MAX))
                imem_addr <= imem_addr + ADDR_W'(1);

            if (accept && (state == HDR_HI))
                hdr_hi_q <= byte_in;

            if (accept && (state == HDR_LO))
                rem_q <= hdr_n;
            else if (state == WRITE)
                rem_q <= rem_q - 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- randomized scoreboard bench for imem_loader.
// Stimulus tasks push expected writes into exp_q; a negedge monitor pops and
// compares on every imem_we. Load outcome is predicted from the header and
// (when IMEM_LOADER_CHECKSUM_EN is defined) the trailing checksum byte.
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] preset[$];
    wr_t         mon_e;
    int          checks = 0;
    int          passes = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    bit          bad_chk_g = 1'b0;
`endif

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every write must match the head of exp_q.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                chk("wr_data", imem_wdata, mon_e.data);
                chk("wr_byte_ready", 32'(byte_ready), 32'd0);
                chk("wr_cpu_reset", 32'(cpu_reset), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int stall, input bit pulse_start);
        bit acc;
        int guard;
        while (int'($urandom_range(0, 99)) < stall) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        start      = pulse_start;
        acc        = 1'b0;
        guard      = 0;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_addr", 32'(imem_addr), 32'd0);
        chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("start_flags", {30'd0, load_done, load_error}, 32'd0);
    endtask

    task automatic wait_outcome(input bit ok);
        int guard = 0;
        while (!(load_done || load_error) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("load_done", 32'(load_done), ok ? 32'd1 : 32'd0);
        chk("load_error", 32'(load_error), ok ? 32'd0 : 32'd1);
        chk("end_cpu_reset", 32'(cpu_reset), ok ? 32'd0 : 32'd1);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Reference: valid iff 1 <= N <= MAX_WORDS; word i goes to address i.
    task automatic run_load(input logic [15:0] n, input int stall, input bit mid_start);
        bit          ok;
        logic [7:0]  x;
        logic [31:0] w;
        pulse_start_load();
        send_byte(n[15:8], stall, 1'b0);
        send_byte(n[7:0], stall, 1'b0);
        ok = (n != 16'd0) && (int'(n) <= MAX_WORDS);
        x  = 8'h00;
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                w = (i < preset.size()) ? preset[i] : $urandom;
                exp_q.push_back('{i, w});
                for (int b = 3; b >= 0; b--) begin
                    send_byte(w[8*b +: 8], stall, mid_start && (i == 0) && (b == 1));
                    x ^= w[8*b +: 8];
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_chk_g ? (x ^ 8'h01) : x, stall, 1'b0);
            if (bad_chk_g) ok = 1'b0;
`endif
        end
        wait_outcome(ok);
    endtask

    initial begin
        #12;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed two-word program.
        preset = '{32'h12345678, 32'h9ABCDEF0};
        run_load(16'd2, 0, 1'b0);
        preset.delete();

        // Header boundaries: 0 and MAX_WORDS+1 abort without writes.
        run_load(16'h0000, 0, 1'b0);
        run_load(16'h0401, 0, 1'b0);

        // Same words, streaming then stalled with a stray start mid-DATA.
        for (int i = 0; i < 8; i++) preset.push_back($urandom);
        run_load(16'd8, 0, 1'b0);
        run_load(16'd8, 40, 1'b1);
        preset.delete();

        // Random lengths and stall rates.
        for (int k = 0; k < 6; k++)
            run_load(16'($urandom_range(1, 24)), int'($urandom_range(0, 50)), 1'b0);

        // Reset mid-load after two data bytes.
        pulse_start_load();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        chk("mid_rst_error", 32'(load_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_load(16'd3, 20, 1'b0);

        // Full-size program: last write lands on address 1023.
        run_load(16'd1024, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        preset = '{32'h01020408};
        bad_chk_g = 1'b0;
        run_load(16'd1, 0, 1'b0);
        bad_chk_g = 1'b1;
        run_load(16'd1, 0, 1'b0);
        bad_chk_g = 1'b0;
        preset.delete();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
